// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the unified instruction/data memory arbiter.
package mem_arbiter_pkg;
  localparam int FULLW           = 32;
  localparam int DEF_MAX_DSTREAK = 3;

  localparam logic [1:0] RSP_NONE = 2'd0;
  localparam logic [1:0] RSP_IF   = 2'd1;
  localparam logic [1:0] RSP_D    = 2'd2;
endpackage

// File: rtl/mem_arbiter_arb_streak.sv
// Fixed data-first priority with a saturating streak counter that forces a fetch
// grant after MAX_DSTREAK consecutive data grants; grants are combinational.
module arb_streak
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_DSTREAK = DEF_MAX_DSTREAK
) (
  input  logic clk,
  input  logic nreset,
  input  logic i_en,
  input  logic i_if_req,
  input  logic i_d_req,
  output logic o_if_gnt,
  output logic o_d_gnt
);
  localparam int SW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] L_MAX = SW'(MAX_DSTREAK);

  logic [SW-1:0] r_dstreak;
  logic          w_fetch_due;

  // Once data has won MAX_DSTREAK times in a row against a waiting fetch, fetch wins.
  assign w_fetch_due = i_if_req && (r_dstreak == L_MAX);
  assign o_d_gnt     = i_en && i_d_req && !w_fetch_due;
  assign o_if_gnt    = i_en && i_if_req && !o_d_gnt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_dstreak <= '0;
    end else if (!i_if_req || o_if_gnt) begin
      r_dstreak <= '0;
    end else if (o_d_gnt && (r_dstreak != L_MAX)) begin
      r_dstreak <= r_dstreak + 1'b1;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between fetch and load/store paths;
// 1-cycle read latency, one grant per cycle, fetch responses killed by branch flush.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW          = FULLW,
  parameter int DW          = FULLW,
  parameter int MAX_DSTREAK = DEF_MAX_DSTREAK
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_ad,
  output logic [DW-1:0] mem_d,
  output logic          mem_we,
  input  logic [DW-1:0] mem_q
);
  logic          r_run;
  logic          r_flush;
  logic [1:0]    r_rsp_state;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          w_if_gnt;
  logic          w_d_gnt;
  logic          w_flush_q;

  // Grants stay off until the first clock edge seen with reset released.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_run <= 1'b0;
    else         r_run <= 1'b1;
  end

  arb_streak #(.MAX_DSTREAK(MAX_DSTREAK)) u_arb (
    .clk      (clk),
    .nreset   (nreset),
    .i_en     (r_run),
    .i_if_req (if_req),
    .i_d_req  (d_req),
    .o_if_gnt (w_if_gnt),
    .o_d_gnt  (w_d_gnt)
  );

  assign if_gnt = w_if_gnt;
  assign d_gnt  = w_d_gnt;
  assign mem_ad = w_d_gnt ? d_addr : (w_if_gnt ? if_addr : '0);
  assign mem_we = w_d_gnt & d_we;
  assign mem_d  = d_wdata;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_rsp_state <= RSP_NONE;
      r_flush     <= 1'b0;
    end else begin
      r_flush <= if_flush;
      if (w_if_gnt)                r_rsp_state <= RSP_IF;
      else if (w_d_gnt && !d_we)   r_rsp_state <= RSP_D;
      else                         r_rsp_state <= RSP_NONE;
    end
  end

  // A flush in the grant cycle or in the return cycle both make the fetch stale.
  assign w_flush_q = r_flush | if_flush;
  assign if_rvalid = (r_rsp_state == RSP_IF) && !w_flush_q;
  assign d_rvalid  = (r_rsp_state == RSP_D);
  assign if_rdata  = if_rvalid ? mem_q : r_if_rdata;
  assign d_rdata   = d_rvalid  ? mem_q : r_d_rdata;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (if_rvalid) r_if_rdata <= mem_q;
      if (d_rvalid)  r_d_rdata  <= mem_q;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a RAM model, a transaction-level reference model and
// directed plus random scenarios.
module tb_mem_arbiter;
  localparam int MAXS = 3;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_ad, mem_d;
  logic [31:0] mem_q;
  logic [31:0] ram [0:31];

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  logic [31:0] ref_mem [0:31];
  int          streak = 0;
  int          pend_kind = 0;  // 0 none, 1 fetch, 2 load
  logic [31:0] pend_data = '0;
  logic        pend_fl = 1'b0;
  logic [31:0] hold_i = '0, hold_d = '0;
  int          wait_cnt = 0;
  logic        obs_ig, obs_dg, last_ei, last_ed;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_ad[4:0]] <= mem_d;
    mem_q <= ram[mem_ad[4:0]];
  end

  mem_arbiter #(.AW(32), .DW(32), .MAX_DSTREAK(MAXS)) dut (
    .clk(clk), .nreset(nreset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_ad(mem_ad), .mem_d(mem_d), .mem_we(mem_we), .mem_q(mem_q)
  );

  // One clock cycle: check the DUT against the model at the negedge, then advance the model.
  task automatic step();
    logic ei, ed, eir, edr;
    logic [31:0] ead;
    @(negedge clk);
    eir = (pend_kind == 1) && !(pend_fl || if_flush);
    edr = (pend_kind == 2);
    if (eir) hold_i = pend_data;
    if (edr) hold_d = pend_data;
    ed  = d_req && !(if_req && streak == MAXS);
    ei  = if_req && !ed;
    ead = ed ? d_addr : (ei ? if_addr : 32'd0);
    obs_ig = if_gnt; obs_dg = d_gnt;
    n_cmp++; if (if_rvalid !== eir) begin n_fail++; $display("FAIL if_rvalid: got %b want %b t=%0t", if_rvalid, eir, $time); end
    n_cmp++; if (d_rvalid !== edr) begin n_fail++; $display("FAIL d_rvalid: got %b want %b t=%0t", d_rvalid, edr, $time); end
    n_cmp++; if (if_rdata !== hold_i) begin n_fail++; $display("FAIL if_rdata: got %h want %h t=%0t", if_rdata, hold_i, $time); end
    n_cmp++; if (d_rdata !== hold_d) begin n_fail++; $display("FAIL d_rdata: got %h want %h t=%0t", d_rdata, hold_d, $time); end
    n_cmp++; if (if_gnt !== ei || d_gnt !== ed) begin n_fail++; $display("FAIL grants: got i%b d%b want i%b d%b t=%0t", if_gnt, d_gnt, ei, ed, $time); end
    n_cmp++; if (mem_ad !== ead) begin n_fail++; $display("FAIL mem_ad: got %h want %h t=%0t", mem_ad, ead, $time); end
    n_cmp++; if (mem_we !== (ed && d_we)) begin n_fail++; $display("FAIL mem_we: got %b want %b t=%0t", mem_we, ed && d_we, $time); end
    if (ed && d_we) begin
      n_cmp++; if (mem_d !== d_wdata) begin n_fail++; $display("FAIL mem_d: got %h want %h", mem_d, d_wdata); end
    end
    if (ei) begin
      n_cmp++; if (wait_cnt > MAXS) begin n_fail++; $display("FAIL starve: waited %0d want <= %0d", wait_cnt, MAXS); end
    end
    // advance the model by one edge
    pend_kind = 0;
    if (ei) begin pend_kind = 1; pend_data = ref_mem[if_addr[4:0]]; pend_fl = if_flush; end
    else if (ed && !d_we) begin pend_kind = 2; pend_data = ref_mem[d_addr[4:0]]; end
    if (ed && d_we) ref_mem[d_addr[4:0]] = d_wdata;
    if (!if_req || ei) streak = 0;
    else if (ed && streak < MAXS) streak++;
    wait_cnt = (if_req && !ei) ? wait_cnt + 1 : 0;
    last_ei = ei; last_ed = ed;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    if_req = 0; d_req = 0; d_we = 0; if_flush = 0;
  endtask

  task automatic test_reset();
    nreset = 0; if_req = 1; d_req = 1; d_we = 1;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if ({if_gnt, d_gnt, mem_we, if_rvalid, d_rvalid} !== 5'b0) begin n_fail++; $display("FAIL reset_ctl: got %b want 00000", {if_gnt, d_gnt, mem_we, if_rvalid, d_rvalid}); end
    n_cmp++; if (if_rdata !== 32'd0 || d_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h %h want 0", if_rdata, d_rdata); end
    @(negedge clk); nreset = 1; #1;
    n_cmp++; if (d_gnt !== 1'b0 || if_gnt !== 1'b0) begin n_fail++; $display("FAIL pre_edge_gnt: got i%b d%b want 0", if_gnt, d_gnt); end
    idle();
    @(posedge clk); #1;
  endtask

  task automatic test_preload();
    for (int a = 0; a < 32; a++) begin
      d_req = 1; d_we = 1; d_addr = a; d_wdata = $urandom;
      step();
    end
    idle(); step();
  endtask

  task automatic test_fetch_only();
    for (int a = 0; a < 3; a++) begin
      if_req = 1; if_addr = a;
      #0;
      n_cmp++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin n_fail++; $display("FAIL fetch_gnt: got i%b d%b want i1 d0", if_gnt, d_gnt); end
      step();
      n_cmp++; if (if_rvalid !== 1'b1 || if_rdata !== ref_mem[a]) begin n_fail++; $display("FAIL fetch_rsp: got %b %h want 1 %h", if_rvalid, if_rdata, ref_mem[a]); end
    end
    idle(); step();
  endtask

  task automatic test_contention();
    for (int k = 0; k < 12; k++) begin
      if_req = 1; if_addr = $urandom_range(0, 31);
      d_req = 1; d_we = 0; d_addr = $urandom_range(0, 31);
      step();
      n_cmp++; if (obs_ig !== (k % 4 == 3) || obs_dg !== (k % 4 != 3)) begin n_fail++; $display("FAIL pattern k=%0d: got i%b d%b", k, obs_ig, obs_dg); end
      n_cmp++; if (if_rvalid !== (k % 4 == 3) || d_rvalid !== (k % 4 != 3)) begin n_fail++; $display("FAIL rsp_pattern k=%0d: got i%b d%b", k, if_rvalid, d_rvalid); end
    end
    idle(); step();
  endtask

  task automatic test_store_load();
    d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF; #0;
    n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL st_we: got %b want 1", mem_we); end
    step();
    d_we = 0; #0;
    n_cmp++; if (mem_we !== 1'b0 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL ld_we: got we%b rv%b want 0 0", mem_we, d_rvalid); end
    step();
    idle(); #0;
    n_cmp++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL st_ld: got %b %h want 1 deadbeef", d_rvalid, d_rdata); end
    step();
  endtask

  task automatic test_flush();
    logic [31:0] b;
    if_req = 1; if_addr = 3; step();
    if_req = 0; if_flush = 1; #0;
    n_cmp++; if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL flush_late: got %b want 0", if_rvalid); end
    step();
    if_req = 1; if_addr = 4; if_flush = 1; step();
    b = 32'd7; if_addr = b; if_flush = 0; #0;
    n_cmp++; if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL flush_grant: got %b want 0", if_rvalid); end
    step();
    idle(); #0;
    n_cmp++; if (if_rvalid !== 1'b1 || if_rdata !== ref_mem[b]) begin n_fail++; $display("FAIL after_flush: got %b %h want 1 %h", if_rvalid, if_rdata, ref_mem[b]); end
    step();
  endtask

  task automatic test_reset_mid();
    d_req = 1; d_we = 0; d_addr = 5; step();
    #2 nreset = 0; #1;
    n_cmp++; if ({d_rvalid, if_rvalid, mem_we, d_gnt} !== 4'b0) begin n_fail++; $display("FAIL mid_reset: got %b want 0000", {d_rvalid, if_rvalid, mem_we, d_gnt}); end
    n_cmp++; if (d_rdata !== 32'd0) begin n_fail++; $display("FAIL mid_reset_rdata: got %h want 0", d_rdata); end
    pend_kind = 0; streak = 0; hold_i = '0; hold_d = '0; wait_cnt = 0;
    #1 nreset = 1; #1;
    n_cmp++; if (d_gnt !== 1'b0) begin n_fail++; $display("FAIL mid_pre_edge: got %b want 0", d_gnt); end
    idle();
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL post_reset_rv: got %b %b want 0 0", if_rvalid, d_rvalid); end
    end
    test_contention();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1000; c++) begin
      if (!(if_req && !last_ei)) begin
        if_req = ($urandom_range(0, 3) != 0); if_addr = $urandom_range(0, 31);
      end
      if (!(d_req && !last_ed)) begin
        d_req = ($urandom_range(0, 2) != 0); d_we = $urandom_range(0, 1);
        d_addr = $urandom_range(0, 31); d_wdata = $urandom;
      end
      if_flush = ($urandom_range(0, 7) == 0);
      #0;
      n_cmp++; if (if_gnt && d_gnt) begin n_fail++; $display("FAIL excl: both grants c=%0d", c); end
      step();
    end
    idle(); step();
  endtask

  initial begin
    last_ei = 0; last_ed = 0;
    test_reset();
    test_preload();
    test_fetch_only();
    test_contention();
    test_store_load();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous `ram` between the instruction-fetch path and the data load/store path.
- Lets the CPU use a single unified memory instead of separate instruction and data RAMs.
- Data accesses get priority. A streak counter guarantees that fetch cannot starve.
- A branch flush cancels an in-flight fetch response, so the decoder never sees a stale instruction.

Parameters:
- AW, 32, address width (matches `FULLW).
- DW, 32, data width (matches `FULLW).
- MAX_DSTREAK, 3, maximum consecutive data grants while a fetch is pending; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- nreset  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  AW  fetch word address.
- if_flush  in  1  branch taken; discard any fetch response returning next cycle.
- if_gnt  out  1  fetch accepted this cycle (combinational).
- if_rvalid  out  1  if_rdata valid (registered).
- if_rdata  out  DW  fetched instruction.
- d_req  in  1  data request; held with d_we, d_addr and d_wdata until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  data access accepted this cycle (combinational).
- d_rvalid  out  1  load data valid (registered; never asserted for stores).
- d_rdata  out  DW  load data.
- mem_ad  out  AW  RAM address.
- mem_d  out  DW  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_q  in  DW  RAM read data; valid the cycle after the address is presented.

Behaviour:
- Reset:
  - nreset low asynchronously clears rsp_state to RSP_NONE, dstreak to 0 and all registered outputs.
  - During reset: if_rvalid=0, d_rvalid=0, mem_we=0, and both grants are 0.
  - Any in-flight response is dropped with no rvalid.
  - After deassertion, the first grant can occur in the cycle after the first rising edge with nreset high.
- Arbitration (combinational, every cycle):
  - If d_req and not (if_req and dstreak==MAX_DSTREAK): d_gnt=1.
  - Otherwise, if if_req: if_gnt=1.
  - At most one grant per cycle. if_gnt and d_gnt are never both 1.
- Memory drive:
  - mem_ad = granted address.
  - mem_we = d_gnt & d_we.
  - mem_d = d_wdata.
  - When there is no grant: mem_ad holds 0 and mem_we=0.
- Streak counter dstreak (0..MAX_DSTREAK):
  - Increments on d_gnt while if_req is high.
  - Clears on if_gnt, or on any cycle with if_req low.
  - Saturates at MAX_DSTREAK.
- Response FSM, register rsp_state, updated at the clock edge:
  - Next state = RSP_IF on if_gnt.
  - Next state = RSP_D on d_gnt & ~d_we.
  - Next state = RSP_NONE otherwise, including stores.
- Outputs in a cycle where rsp_state = RSP_IF:
  - if_rvalid = ~if_flush_q.
  - if_rdata = mem_q.
  - if_flush_q is if_flush registered in the grant cycle, ORed with if_flush in the current cycle.
  - A flush in either cycle kills the response.
- Outputs in a cycle where rsp_state = RSP_D: d_rvalid=1 and d_rdata=mem_q.
- rdata outputs hold their last value when rvalid=0.
- Throughput: fully pipelined, one access per cycle, read latency 1 cycle after grant.
- Back-to-back grants to different requesters are legal. The response tag tracks ownership.
- A store followed by a load to the same address in the next cycle returns the stored data (the RAM writes at the edge).
- if_flush while if_req is held with no grant has no effect on arbitration. The requester owns address update.

Decomposition:
- The shared defines header gets `RSP_NONE=2'd0, `RSP_IF=2'd1 and `RSP_D=2'd2, plus `MAX_DSTREAK. It reuses `FULLW.
- Natural sub-module: `arb_streak`, the saturating streak counter plus priority decision. It outputs the two grants.
- The response FSM and output registers stay in the top module.

Test Plan:
- Fetch only: if_req=1, addrs 0,1,2 on consecutive cycles → if_gnt=1 each cycle; if_rvalid=1 with mem contents one cycle after each grant; d_gnt=0.
- Contention: if_req=1 and d_req=1 (load) continuously, MAX_DSTREAK=3 → grant pattern D,D,D,IF repeating; d_rvalid and if_rvalid follow the same pattern delayed by 1 cycle.
- Store then load: d_we=1, addr 0x10, wdata 0xDEADBEEF, then d_we=0, addr 0x10 → mem_we=1 only in cycle 1; no d_rvalid for the store; d_rvalid=1 with d_rdata=0xDEADBEEF one cycle after the load grant.
- Flush:
  - if_gnt at cycle N with if_flush=1 at N+1 → if_rvalid=0 at N+1.
  - if_flush=1 at grant cycle N → if_rvalid=0 at N+1.
  - An unflushed fetch at N+1 → if_rvalid=1 at N+2.
- Reset mid-operation: drop nreset asynchronously between edges while a load is in flight → d_rvalid, if_rvalid and mem_we go 0 immediately; after release with no requests, no rvalid is ever asserted; dstreak restarts at 0.
- Exclusivity check: random if_req/d_req/d_we for 1000 cycles → never if_gnt&d_gnt; with fetch continuously pending, fetch always gets a grant within MAX_DSTREAK+1 cycles.
